// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E integer core: FETCH/DECODE/EXECUTE/WRITEBACK sequencer,
// internal register file and ALU, sticky illegal-instruction trap and debug read port.
module riscv_multicycle_core #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DBG_W    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic             retire,
    output logic             illegal,
    input  logic [DBG_W-1:0] debug_sel,
    output logic [31:0]      debug_out
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    localparam logic [5:0] NREGS_W = 6'(NREGS);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    alu_op_t     alu_op;
    logic [31:0] regs [NREGS];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rd_ok, rs1_ok, rs2_ok;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] i_imm, u_imm;
    logic        dec_illegal, dec_use_imm, dec_lui;
    alu_op_t     dec_op;

    function automatic alu_op_t op_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  op_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op_of = ALU_SLL;
            3'b010:  op_of = ALU_SLT;
            3'b011:  op_of = ALU_SLTU;
            3'b100:  op_of = ALU_XOR;
            3'b101:  op_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op_of = ALU_OR;
            default: op_of = ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] x,
                                        input logic [31:0] y);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        xs = x;
        ys = y;
        case (op)
            ALU_ADD:  alu = x + y;
            ALU_SUB:  alu = x - y;
            ALU_SLL:  alu = x << y[4:0];
            ALU_SLT:  alu = {31'b0, xs < ys};
            ALU_SLTU: alu = {31'b0, x < y};
            ALU_XOR:  alu = x ^ y;
            ALU_SRL:  alu = x >> y[4:0];
            ALU_SRA:  alu = xs >>> y[4:0];
            ALU_OR:   alu = x | y;
            ALU_AND:  alu = x & y;
            default:  alu = '0;
        endcase
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign rd_ok  = {1'b0, rd}  < NREGS_W;
    assign rs1_ok = {1'b0, rs1} < NREGS_W;
    assign rs2_ok = {1'b0, rs2} < NREGS_W;
    assign i_imm  = {{20{ir[31]}}, ir[31:20]};
    assign u_imm  = {ir[31:12], 12'b0};

    // Out-of-range indices never reach the array; such encodings trap anyway.
    assign rs1_val = rs1_ok ? regs[ir[15 +: DBG_W]] : '0;
    assign rs2_val = rs2_ok ? regs[ir[20 +: DBG_W]] : '0;

    assign imem_addr = pc;
    assign debug_out = (debug_sel == '0) ? '0 : regs[debug_sel];

    always_comb begin
        dec_illegal = 1'b0;
        dec_use_imm = 1'b0;
        dec_lui     = 1'b0;
        dec_op      = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                dec_op = op_of(funct3, funct7[5]);
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    dec_illegal = 1'b1;
                if (!(rd_ok && rs1_ok && rs2_ok))
                    dec_illegal = 1'b1;
            end
            7'b0010011: begin
                dec_use_imm = 1'b1;
                dec_op = op_of(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    dec_illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec_illegal = 1'b1;
                if (!(rd_ok && rs1_ok))
                    dec_illegal = 1'b1;
            end
            7'b0110111: begin
                dec_use_imm = 1'b1;
                dec_lui     = 1'b1;
                if (!rd_ok)
                    dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            imem_req <= 1'b1;
            retire   <= 1'b0;
            illegal  <= 1'b0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            r        <= '0;
            alu_op   <= ALU_ADD;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= dec_lui ? 32'b0 : rs1_val;
                    b      <= dec_lui ? u_imm : (dec_use_imm ? i_imm : rs2_val);
                    alu_op <= dec_op;
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                        state   <= S_TRAP;
                    end else begin
                        state   <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r      <= alu(alu_op, a, b);
                    retire <= 1'b1;
                    state  <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (rd != 5'd0)
                        regs[ir[7 +: DBG_W]] <= r;
                    pc       <= pc + 32'd4;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: a 32-register core running a short
// program with wait states and a trap, plus a 16-register core for RV32E limits.
module tb_riscv_multicycle_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_valid, retire, illegal;
    logic [31:0] imem_addr, imem_rdata, debug_out;
    logic [4:0]  debug_sel;

    logic        rst16_n;
    logic        imem_req16, imem_valid16, retire16, illegal16;
    logic [31:0] imem_addr16, imem_rdata16, debug_out16;
    logic [3:0]  debug_sel16;

    logic [31:0] prog   [16];
    logic [31:0] prog16 [4];

    int errors = 0;
    int checks = 0;

    assign imem_rdata   = prog[imem_addr[5:2]];
    assign imem_rdata16 = prog16[imem_addr16[3:2]];

    riscv_multicycle_core #(.NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .retire(retire),
        .illegal(illegal), .debug_sel(debug_sel), .debug_out(debug_out)
    );

    riscv_multicycle_core #(.NREGS(16), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .rst_n(rst16_n), .imem_req(imem_req16), .imem_addr(imem_addr16),
        .imem_valid(imem_valid16), .imem_rdata(imem_rdata16), .retire(retire16),
        .illegal(illegal16), .debug_sel(debug_sel16), .debug_out(debug_out16)
    );

    // Runs one instruction on the 32-register core; counts cycles until it is back in
    // FETCH and how many sampled cycles showed imem_req with the expected address.
    task automatic do_instr(input int waits, input logic [31:0] exp_addr,
                            output int cycles, output int req_hold);
        cycles   = 0;
        req_hold = 0;
        imem_valid = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            if (imem_req === 1'b1 && imem_addr === exp_addr) req_hold++;
            @(posedge clk); #1; cycles++;
        end
        imem_valid = 1'b1;
        if (imem_req === 1'b1 && imem_addr === exp_addr) req_hold++;
        @(posedge clk); #1; cycles++;
        while (retire !== 1'b1 && cycles < waits + 20) begin
            @(posedge clk); #1; cycles++;
        end
        @(posedge clk); #1; cycles++;
    endtask

    task automatic rd_reg(input logic [4:0] idx, output logic [31:0] v);
        debug_sel = idx;
        #1;
        v = debug_out;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        checks++; if (retire !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags: retire=%b illegal=%b want 0 0", retire, illegal); end
        rd_reg(5'd1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_x1: got %h want 00000000", v); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi;
        int cyc, hold;
        logic [31:0] v;
        do_instr(0, 32'h0, cyc, hold);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL addi1_cycles: got %0d want 4", cyc); end
        rd_reg(5'd1, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL addi_x1: got %h want 00000005", v); end
        checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL addi1_pc: got %h req %b want 00000004 1", imem_addr, imem_req); end
        do_instr(0, 32'h4, cyc, hold);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL addi2_cycles: got %0d want 4", cyc); end
        rd_reg(5'd2, v);
        checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL addi_x2: got %h want fffffffd", v); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL addi2_pc: got %h want 00000008", imem_addr); end
    endtask

    task automatic test_alu;
        int cyc, hold;
        logic [31:0] v;
        do_instr(0, 32'h08, cyc, hold);
        do_instr(0, 32'h0C, cyc, hold);
        do_instr(0, 32'h10, cyc, hold);
        do_instr(0, 32'h14, cyc, hold);
        rd_reg(5'd3, v);
        checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL sub_x3: got %h want 00000008", v); end
        rd_reg(5'd4, v);
        checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL srai_x4: got %h want fffffffe", v); end
        rd_reg(5'd5, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sltu_x5: got %h want 00000000", v); end
        rd_reg(5'd7, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL slt_x7: got %h want 00000001", v); end
        checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL alu_pc: got %h want 00000018", imem_addr); end
    endtask

    task automatic test_x0_and_lui;
        int cyc, hold;
        logic [31:0] v;
        do_instr(0, 32'h18, cyc, hold);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL x0_retire_cycles: got %0d want 4", cyc); end
        rd_reg(5'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL x0_read: got %h want 00000000", v); end
        checks++; if (imem_addr !== 32'h1C) begin errors++; $display("FAIL x0_pc: got %h want 0000001c", imem_addr); end
        do_instr(0, 32'h1C, cyc, hold);
        rd_reg(5'd6, v);
        checks++; if (v !== 32'h1234_5000) begin errors++; $display("FAIL lui_x6: got %h want 12345000", v); end
    endtask

    task automatic test_illegal;
        int ret_seen, addr_moved;
        imem_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_in_decode: got %b want 0", illegal); end
        @(posedge clk); #1;
        checks++; if (illegal !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL ill_trap: illegal=%b req=%b want 1 0", illegal, imem_req); end
        ret_seen = 0;
        addr_moved = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (retire !== 1'b0) ret_seen++;
            if (imem_addr !== 32'h20 || illegal !== 1'b1 || imem_req !== 1'b0) addr_moved++;
        end
        checks++; if (ret_seen !== 0) begin errors++; $display("FAIL ill_no_retire: got %0d pulses want 0", ret_seen); end
        checks++; if (addr_moved !== 0) begin errors++; $display("FAIL ill_frozen: got %0d bad cycles want 0", addr_moved); end
        rst_n = 1'b0;
        #1;
        checks++; if (illegal !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL ill_reset: illegal=%b addr=%h req=%b want 0 00000000 1", illegal, imem_addr, imem_req); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_wait_states;
        int cyc, hold;
        logic [31:0] v;
        do_instr(0, 32'h0, cyc, hold);
        do_instr(3, 32'h4, cyc, hold);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL wait_cycles: got %0d want 7", cyc); end
        checks++; if (hold !== 4) begin errors++; $display("FAIL wait_req_hold: got %0d want 4", hold); end
        rd_reg(5'd2, v);
        checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL wait_x2: got %h want fffffffd", v); end
        rd_reg(5'd1, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL wait_x1: got %h want 00000005", v); end
    endtask

    task automatic test_nregs16;
        debug_sel16 = 4'd1;
        rst16_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst16_n = 1'b0;
        #1;
        checks++; if (imem_addr16 !== 32'h0 || imem_req16 !== 1'b1 || retire16 !== 1'b0) begin errors++; $display("FAIL rv32e_midreset: addr=%h req=%b retire=%b want 00000000 1 0", imem_addr16, imem_req16, retire16); end
        @(posedge clk); #1;
        checks++; if (debug_out16 !== 32'h0) begin errors++; $display("FAIL rv32e_x1_kept0: got %h want 00000000", debug_out16); end
        rst16_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (debug_out16 !== 32'd9 || imem_addr16 !== 32'h4) begin errors++; $display("FAIL rv32e_addi: x1=%h addr=%h want 00000009 00000004", debug_out16, imem_addr16); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (illegal16 !== 1'b1 || imem_addr16 !== 32'h4 || imem_req16 !== 1'b0) begin errors++; $display("FAIL rv32e_x16_illegal: illegal=%b addr=%h req=%b want 1 00000004 0", illegal16, imem_addr16, imem_req16); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = 32'h0050_0093;  // ADDI x1,x0,5
        prog[1] = 32'hFFD0_0113;  // ADDI x2,x0,-3
        prog[2] = 32'h4020_81B3;  // SUB  x3,x1,x2
        prog[3] = 32'h4011_5213;  // SRAI x4,x2,1
        prog[4] = 32'h0011_32B3;  // SLTU x5,x2,x1
        prog[5] = 32'h0011_23B3;  // SLT  x7,x2,x1
        prog[6] = 32'h0070_0013;  // ADDI x0,x0,7
        prog[7] = 32'h1234_5337;  // LUI  x6,0x12345
        prog[8] = 32'h0000_0000;  // illegal
        prog16[0] = 32'h0090_0093;  // ADDI x1,x0,9
        prog16[1] = 32'h0010_0813;  // ADDI x16,x0,1
        prog16[2] = 32'h0;
        prog16[3] = 32'h0;
        rst_n = 1'b0;
        rst16_n = 1'b0;
        imem_valid = 1'b1;
        imem_valid16 = 1'b1;
        debug_sel = 5'd0;
        debug_sel16 = 4'd0;

        test_reset();
        test_addi();
        test_alu();
        test_x0_and_lui();
        test_illegal();
        test_wait_states();
        test_nregs16();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Parametrised multi-cycle RV32I integer core: fetches instructions over a valid/ready-style memory port, decodes, executes on an internal ALU and writes back to an internal register file. It is the next generation of the single-cycle top: it owns its own PC and sequencing FSM, supports immediate forms, detects illegal encodings and exposes a selectable debug read port. It sits between instruction memory and the debug/testbench harness.

## Interface

- NREGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E); x0 hardwired zero
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DBG_W, $clog2(NREGS), debug select width (derived, not overridden)

Ports:

- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- imem_req  out  1  fetch request; high only in state FETCH
- imem_addr  out  32  current PC, word aligned
- imem_valid  in  1  instruction returned; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_valid
- retire  out  1  one-cycle pulse in WRITEBACK
- illegal  out  1  sticky; core halted in TRAP
- debug_sel  in  DBG_W  register index for debug read
- debug_out  out  32  combinational read of register debug_sel (0 for x0)

## Operation

- States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; DECODE -> TRAP on illegal; TRAP is terminal until reset.
- FETCH: imem_req=1, imem_addr=PC; on clk edge with imem_valid=1, latch imem_rdata into IR and go to DECODE; otherwise stay (wait states unbounded).
- DECODE: read rs1/rs2 into operand latches A/B; form sign-extended I-immediate or U-immediate; classify.
- Supported: OP (0110011) ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; OP-IMM (0010011) ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; LUI (0110111).
- Illegal: any other opcode; OP with funct7 not 0000000 (or 0100000 for SUB/SRA); SLLI/SRLI with imm[11:5]!=0; SRAI with imm[11:5]!=0100000; any rs1/rs2/rd index >= NREGS.
- EXECUTE: ALU result latched into R. Shifts use low 5 bits of operand B; SLT signed, SLTU unsigned; arithmetic wraps modulo 2^32; LUI result = imm[31:12]<<12.
- WRITEBACK: write R to rd unless rd=0; PC <= PC+4 (wraps at 2^32); retire=1.
- TRAP: illegal=1, imem_req=0, no register writes, PC frozen at faulting instruction.

## Timing

- Reset values: state=FETCH, PC=RESET_PC, imem_req=1, imem_addr=RESET_PC, retire=0, illegal=0, all registers 0, IR/A/B/R 0; debug_out=0.
- Reset assertion at any state takes effect immediately (asynchronous); an in-flight fetch is abandoned and no write occurs.
- Zero-wait memory: 4 cycles per instruction; retire pulses every 4th cycle.
- N wait cycles of imem_valid=0 add N cycles in FETCH; imem_addr stable throughout.
- Register write lands on the WRITEBACK edge; the next instruction's DECODE reads the new value (no hazards: strictly sequential).
- debug_out reflects a write on the cycle after the WRITEBACK edge.
- illegal rises on the edge leaving DECODE; retire never pulses for the faulting instruction.

## Test plan

- ADDI x1,x0,5 (0x00500093) then ADDI x2,x0,-3 (0xFFD00113), zero wait -> retire at cycles 4 and 8; x1=5, x2=0xFFFFFFFD; imem_addr 0x0, 0x4, 0x8.
- SUB x3,x1,x2 (0x402081B3) then SRAI x4,x2,1 (0x40115213) -> x3=0x00000008, x4=0xFFFFFFFE; SLTU x5,x2,x1 -> x5=0.
- ADDI x0,x0,7 (0x00700013) -> debug_sel=0 reads 0; retire still pulses; PC advances by 4.
- imem_valid held low 3 cycles on second fetch -> imem_req/imem_addr=0x4 held 4 cycles; instruction takes 7 cycles; results unchanged.
- Fetch 0x00000000 -> illegal=1 after DECODE, imem_req=0, imem_addr frozen, no retire; persists until rst_n low, then PC=RESET_PC, illegal=0.
- NREGS=16: ADDI x16,x0,1 -> illegal; reset asserted mid-EXECUTE of ADDI x1,x0,9 -> x1 stays 0, state FETCH, PC=RESET_PC.
